// File: rtl/piccolo_ctrl_pkg.sv
// piccolo_ctrl_pkg: shared state encoding and default round/index parameters for the Piccolo round controller
package piccolo_ctrl_pkg;
  localparam int DEF_R80 = 25;
  localparam int DEF_R128 = 31;
  localparam int DEF_IDX_W = 5;
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    ROUND = 3'd2,
    FINAL = 3'd3,
    DONE  = 3'd4
  } state_t;
endpackage

// File: rtl/piccolo_round_counter.sv
// piccolo_round_counter: round counter with clear, saturating increment and terminal-count compare against a dynamic limit
module piccolo_round_counter #(
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [IDX_W-1:0] limit,
  output logic [IDX_W-1:0] cnt,
  output logic             tc
);
  assign tc = cnt == limit;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc && !tc) cnt <= cnt + 1'b1;
endmodule

// File: rtl/piccolo_round_ctrl.sv
// piccolo_round_ctrl: Piccolo round sequencer (load, R rounds, post-whitening, result hold)
// Define PICCOLO_CTRL_ABORT_EN to add the abort input that forces any busy state back to IDLE.
module piccolo_round_ctrl
  import piccolo_ctrl_pkg::*;
#(
  parameter int R80   = DEF_R80,
  parameter int R128  = DEF_R128,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef PICCOLO_CTRL_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic             key128,
  input  logic             decrypt,
  input  logic             out_ready,
  output logic             ready,
  output logic             load_en,
  output logic             round_en,
  output logic             rp_bypass,
  output logic             whiten_post,
  output logic [IDX_W-1:0] rk_idx,
  output logic             out_valid
);
  state_t state, state_n;
  logic key128_q, decrypt_q, clr, inc, tc, kill;
  logic [IDX_W-1:0] cnt, lim;
  assign lim = key128_q ? IDX_W'(R128 - 1) : IDX_W'(R80 - 1);
`ifdef PICCOLO_CTRL_ABORT_EN
  assign kill = abort && state != IDLE;
`else
  assign kill = 1'b0;
`endif
  piccolo_round_counter #(.IDX_W(IDX_W)) u_cnt (
    .clk(clk), .rst_n(rst_n), .clr(clr), .inc(inc), .limit(lim), .cnt(cnt), .tc(tc)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      key128_q <= 1'b0;
      decrypt_q <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && start) begin
        key128_q <= key128;
        decrypt_q <= decrypt;
      end
    end
  // Abort overrides everything, including the round advance and out_ready.
  always_comb begin
    state_n = state;
    clr = 1'b0;
    inc = 1'b0;
    case (state)
      IDLE:  state_n = start ? LOAD : IDLE;
      LOAD: begin
        clr = 1'b1;
        state_n = ROUND;
      end
      ROUND: begin
        inc = !tc;
        clr = tc;
        state_n = tc ? FINAL : ROUND;
      end
      FINAL: state_n = DONE;
      DONE:  state_n = out_ready ? IDLE : DONE;
      default: begin
        clr = 1'b1;
        state_n = IDLE;
      end
    endcase
    if (kill) begin
      state_n = IDLE;
      clr = 1'b1;
      inc = 1'b0;
    end
  end
  assign ready       = state == IDLE;
  assign load_en     = state == LOAD;
  assign round_en    = state == ROUND;
  assign rp_bypass   = round_en && tc;
  assign whiten_post = state == FINAL;
  assign out_valid   = state == DONE;
  assign rk_idx      = round_en ? (decrypt_q ? lim - cnt : cnt) : '0;
endmodule
